// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

    // Control states of the divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 4;

endpackage : div_pkg

// File: rtl/trial_sub.sv
// Trial subtractor: diff = a - b formed as a + ~b + 1.
// The top bit of the difference serves as the borrow (negative result).
module trial_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    assign diff   = a + ~b + N'(1);
    assign borrow = diff[N-1];

endmodule : trial_sub

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one trial subtraction per clock.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE); a sampled start latches dividend/divisor. busy is high exactly
// while steps run, done pulses for one cycle when results are valid, and
// quotient/remainder/div_by_zero hold until the next result is produced.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output state_t           state_dbg
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [2*WIDTH:0] w_rq_shift;
    logic [WIDTH:0]   w_r_shift;
    logic [WIDTH-1:0] w_q_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // {R,Q} shifted left by one; the bit leaving R's top is always zero.
    assign w_rq_shift = {r_r, r_q} << 1;
    assign w_r_shift  = w_rq_shift[2*WIDTH:WIDTH];
    assign w_q_shift  = w_rq_shift[WIDTH-1:0];

    trial_sub #(.N(WIDTH + 1)) u_trial_sub (
        .a      (w_r_shift),
        .b      ({1'b0, r_d}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // Restore R on borrow; otherwise keep the difference and set the quotient bit.
    assign w_r_next = w_borrow ? w_r_shift : w_diff;
    assign w_q_next = {w_q_shift[WIDTH-1:1], ~w_borrow};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one restoring step per RUN cycle, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_r   <= '0;
            r_d   <= divisor;
            r_cnt <= '0;
            if (divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_q   <= w_q_next;
            r_r   <= w_r_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_r_next[WIDTH-1:0];
                r_dbz       <= 1'b0;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign state_dbg   = r_state;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios, exhaustive sweep and random
// operations, all checked against plain-arithmetic division.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = DIV_WIDTH_DEFAULT;

    // Clock / reset
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    state_t       state_dbg;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Last results the outputs must keep showing until the next done.
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model
    function automatic logic [W-1:0] model_q(input int dd, input int dv);
        if (dv == 0) return W'((1 << W) - 1);
        return W'(dd / dv);
    endfunction

    function automatic logic [W-1:0] model_r(input int dd, input int dv);
        if (dv == 0) return W'(dd);
        return W'(dd % dv);
    endfunction

    // Driver: present a request and hold it across one rising edge.
    task automatic issue(input int dd, input int dv);
        start    = 1'b1;
        dividend = W'(dd);
        divisor  = W'(dv);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom_range(0, (1 << W) - 1));
        divisor  = W'($urandom_range(0, (1 << W) - 1));
    endtask

    // Wait (bounded) for done after an accepted request; check timing, hold and results.
    // glitch > 0 pulses start with other operands at that sample while running.
    task automatic wait_done(input int dd, input int dv, input int glitch, input string tag);
        int n     = 0;
        int nbusy = 0;
        bit seen  = 0;
        while (!seen && n < 3 * W + 5) begin
            @(negedge clk);
            n++;
            check({tag, "_busy_and_done"}, {31'b0, busy & done}, 32'd0);
            if (busy) nbusy++;
            if (done) seen = 1;
            else check({tag, "_hold"}, {quotient, remainder, div_by_zero}, {prev_q, prev_r, prev_z});
            if (n == glitch) begin
                start    = 1'b1;
                dividend = W'(12);
                divisor  = W'(5);
            end else if (n == glitch + 1) begin
                start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_latency"}, n, (dv == 0) ? 1 : W + 1);
        check({tag, "_busy_cycles"}, nbusy, (dv == 0) ? 0 : W);
        check({tag, "_quotient"}, quotient, model_q(dd, dv));
        check({tag, "_remainder"}, remainder, model_r(dd, dv));
        check({tag, "_div_by_zero"}, div_by_zero, (dv == 0) ? 1 : 0);
        prev_q = model_q(dd, dv);
        prev_r = model_r(dd, dv);
        prev_z = (dv == 0);
    endtask

    task automatic idle_cycles(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_idle_busy_done"}, {busy, done}, 32'd0);
            check({tag, "_idle_hold"}, {quotient, remainder, div_by_zero}, {prev_q, prev_r, prev_z});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_z   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {quotient, remainder, busy, done, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2, "post_reset");

        // 13 / 4
        issue(13, 4);
        wait_done(13, 4, -1, "d13_4");
        idle_cycles(2, "after_13_4");

        // 15 / 1 then 3 / 9 back-to-back
        issue(15, 1);
        wait_done(15, 1, -1, "d15_1");
        issue(3, 9);
        wait_done(3, 9, -1, "d3_9");
        idle_cycles(1, "after_b2b");

        // 7 / 0, then a valid divide clears the flag
        issue(7, 0);
        wait_done(7, 0, -1, "d7_0");
        idle_cycles(1, "after_div0");
        issue(5, 2);
        wait_done(5, 2, -1, "d5_2");
        idle_cycles(1, "after_5_2");

        // start pulsed while 9 / 2 runs is ignored
        issue(9, 2);
        wait_done(9, 2, 2, "d9_2_glitch");
        idle_cycles(W + 2, "no_queued_op");

        // reset in the middle of 14 / 3
        issue(14, 3);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {quotient, remainder, busy, done, div_by_zero}, 32'd0);
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        idle_cycles(W + 2, "in_reset");
        rst_n = 1'b1;
        idle_cycles(1, "after_reset");
        issue(14, 3);
        wait_done(14, 3, -1, "d14_3");
        idle_cycles(1, "after_14_3");

        // Exhaustive sweep, randomly mixing back-to-back and idle gaps
        for (int dd = 0; dd < (1 << W); dd++) begin
            for (int dv = 0; dv < (1 << W); dv++) begin
                issue(dd, dv);
                wait_done(dd, dv, -1, "sweep");
                if ($urandom_range(0, 1) == 1) idle_cycles(1, "sweep_gap");
            end
        end

        // Random operations
        for (int i = 0; i < 40; i++) begin
            int dd;
            int dv;
            dd = $urandom_range(0, (1 << W) - 1);
            dv = $urandom_range(0, (1 << W) - 1);
            issue(dd, dv);
            wait_done(dd, dv, -1, "rand");
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), "rand_gap");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_divider
